// File: rtl/jtag_debug_cmd_dispatch.sv
// Purpose: system-clock side of the virtual-JTAG link; syncs update strobes, queues {ir, sr} commands.
// Latency: vs_udr rise -> cmd_valid in SYNC_STAGES+1 clk; pop -> jdo/take_* pulse 1 clk after handshake.
// Backpressure: cmd_ready stalls the queue; an update-DR arriving while full (no pop) is dropped, overflow set.
module jtag_debug_cmd_dispatch #(
   parameter int IR_WIDTH    = 2,
   parameter int SR_WIDTH    = 38,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ACTION_BIT  = 37
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         vs_udr,
   input  logic                         vs_uir,
   input  logic [IR_WIDTH-1:0]          ir_in,
   input  logic [SR_WIDTH-1:0]          sr,
   output logic                         cmd_valid,
   input  logic                         cmd_ready,
   output logic [IR_WIDTH-1:0]          cmd_ir,
   output logic [SR_WIDTH-1:0]          jdo,
   output logic [(1<<IR_WIDTH)-1:0]     take_action,
   output logic [(1<<IR_WIDTH)-1:0]     take_no_action,
   output logic                         ir_update,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow,
   input  logic                         overflow_clr
);

   localparam int NCMD = 1 << IR_WIDTH;
   localparam int PW   = $clog2(DEPTH);
   localparam int LW   = $clog2(DEPTH+1);
   localparam int AW   = $clog2(SYNC_STAGES+2);
   localparam logic [AW-1:0] ARM_DONE = AW'(SYNC_STAGES+1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [SYNC_STAGES-1:0] udr_sync;
   logic [SYNC_STAGES-1:0] uir_sync;
   logic                   udr_edge_q;
   logic                   uir_edge_q;
   logic [AW-1:0]          arm_cnt;
   logic                   armed;
   logic                   udr_rise;
   logic                   uir_rise;

   logic [IR_WIDTH-1:0]    mem_ir [DEPTH];
   logic [SR_WIDTH-1:0]    mem_sr [DEPTH];
   logic [PW-1:0]          wptr;
   logic [PW-1:0]          rptr;
   logic                   full;
   logic                   pop;
   logic                   push_ok;
   logic                   drop;
   logic [NCMD-1:0]        head_onehot;

   // Synchronise both TCK-domain strobes; edge flops always follow the synchroniser output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         udr_sync   <= '0;
         uir_sync   <= '0;
         udr_edge_q <= 1'b0;
         uir_edge_q <= 1'b0;
      end else begin
         udr_sync   <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
         uir_sync   <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
         udr_edge_q <= udr_sync[SYNC_STAGES-1];
         uir_edge_q <= uir_sync[SYNC_STAGES-1];
      end
   end

   // Hold off edge detection until the synchroniser and edge flop reflect post-reset levels
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         arm_cnt <= '0;
      else if (arm_cnt != ARM_DONE)
         arm_cnt <= arm_cnt + AW'(1);
   end

   assign armed    = (arm_cnt == ARM_DONE);
   assign udr_rise = armed && udr_sync[SYNC_STAGES-1] && !udr_edge_q;
   assign uir_rise = armed && uir_sync[SYNC_STAGES-1] && !uir_edge_q;

   assign cmd_valid   = (level != '0);
   assign full        = (level == FULL_LVL);
   assign pop         = cmd_valid && cmd_ready;
   assign push_ok     = udr_rise && (!full || pop);
   assign drop        = udr_rise && full && !pop;
   assign cmd_ir      = cmd_valid ? mem_ir[rptr] : '0;
   assign head_onehot = NCMD'(1) << mem_ir[rptr];

   // Command storage; contents need no reset since cmd_valid gates every use
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_ir[wptr] <= ir_in;
         mem_sr[wptr] <= sr;
      end
   end

   // Pointers, occupancy and sticky overflow (a drop outranks a same-cycle clear)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + PW'(1);
         if (pop)     rptr <= rptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (overflow_clr)
            overflow <= 1'b0;
      end
   end

   // Registered pop side-effects: data capture and one-hot action pulses, plus IR update pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jdo            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         ir_update      <= 1'b0;
      end else begin
         ir_update      <= uir_rise;
         take_action    <= '0;
         take_no_action <= '0;
         if (pop) begin
            jdo <= mem_sr[rptr];
            if (mem_sr[rptr][ACTION_BIT])
               take_action    <= head_onehot;
            else
               take_no_action <= head_onehot;
         end
      end
   end

endmodule

// File: tb/tb_jtag_debug_cmd_dispatch.sv
// Purpose: directed, table-driven check of jtag_debug_cmd_dispatch with default parameters.
// Latency: expectations are cycle-exact relative to core clock edges.
// Backpressure: cmd_ready is driven explicitly to exercise stall, full, and drain cases.
module tb_jtag_debug_cmd_dispatch;

   logic        clk = 1'b0;
   logic        reset;
   logic        vs_udr;
   logic        vs_uir;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_ir;
   logic [37:0] jdo;
   logic [3:0]  take_action;
   logic [3:0]  take_no_action;
   logic        ir_update;
   logic [2:0]  level;
   logic        overflow;
   logic        overflow_clr;

   int checks = 0;
   int errors = 0;

   jtag_debug_cmd_dispatch dut (
      .clk            (clk),
      .reset          (reset),
      .vs_udr         (vs_udr),
      .vs_uir         (vs_uir),
      .ir_in          (ir_in),
      .sr             (sr),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_ir         (cmd_ir),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .ir_update      (ir_update),
      .level          (level),
      .overflow       (overflow),
      .overflow_clr   (overflow_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] data;
      logic [3:0]  act;
      logic [3:0]  noact;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one update-DR: strobe high for 4 clk (push lands on the 3rd edge), then low for 4 clk
   task automatic pulse_udr(input logic [1:0] ir, input logic [37:0] data);
      ir_in  = ir;
      sr     = data;
      vs_udr = 1'b1;
      repeat (4) tick();
      vs_udr = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      logic [37:0] d4;
      int          cnt;
      logic        bad;

      vecs[0] = '{ir: 2'd3, data: 38'h20_1234_5678, act: 4'b1000, noact: 4'b0000};
      vecs[1] = '{ir: 2'd0, data: 38'h1F_FFFF_FFFF, act: 4'b0000, noact: 4'b0001};
      vecs[2] = '{ir: 2'd2, data: 38'h3F_FFFF_FFFF, act: 4'b0100, noact: 4'b0000};
      vecs[3] = '{ir: 2'd1, data: 38'h00_0000_0000, act: 4'b0000, noact: 4'b0010};

      // reset with vs_udr already high
      reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = '0; sr = '0;
      cmd_ready = 1'b0; overflow_clr = 1'b0;
      tick();
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_level", level, 0);
      check("rst_jdo", jdo, 0);
      check("rst_pulses", {take_action, take_no_action, ir_update, overflow}, 0);

      // test 1: strobe held through release must not push
      reset = 1'b0;
      bad = 1'b0;
      repeat (20) begin
         tick();
         if (cmd_valid !== 1'b0 || level !== 3'd0) bad = 1'b1;
      end
      check("held_udr_no_push", bad, 0);
      vs_udr = 1'b0;
      repeat (4) tick();

      // test 2: latency and single action pulse
      cmd_ready = 1'b1; ir_in = 2'b01; sr = 38'h20_0000_00AB;
      vs_udr = 1'b1;
      tick(); check("lat_e1", cmd_valid, 0);
      tick(); check("lat_e2", cmd_valid, 0);
      tick(); check("lat_e3", cmd_valid, 1);
      tick();
      check("t2_jdo", jdo, 38'h20_0000_00AB);
      check("t2_take_action", take_action, 4'b0010);
      check("t2_take_no_action", take_no_action, 0);
      check("t2_level", level, 0);
      tick();
      check("t2_pulse_width", take_action, 0);
      vs_udr = 1'b0; cmd_ready = 1'b0;
      repeat (4) tick();

      // table: single command each, pop on demand
      for (int i = 0; i < 4; i++) begin
         pulse_udr(vecs[i].ir, vecs[i].data);
         check("tbl_valid", cmd_valid, 1);
         check("tbl_cmd_ir", cmd_ir, vecs[i].ir);
         check("tbl_level1", level, 1);
         cmd_ready = 1'b1;
         tick();
         cmd_ready = 1'b0;
         check("tbl_jdo", jdo, vecs[i].data);
         check("tbl_act", take_action, vecs[i].act);
         check("tbl_noact", take_no_action, vecs[i].noact);
         check("tbl_level0", level, 0);
         tick();
         check("tbl_pulse_clear", {take_action, take_no_action}, 0);
      end

      // test 3: five no-action updates into a 4-deep FIFO, then drain
      for (int i = 0; i < 5; i++)
         pulse_udr(2'(i % 4), 38'(64'h100 + i));
      check("t3_level_full", level, 4);
      check("t3_overflow", overflow, 1);
      check("t3_head_ir", cmd_ir, 0);
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_drain_noact", take_no_action, 4'b0001 << i);
         check("t3_drain_act", take_action, 0);
         check("t3_drain_jdo", jdo, 38'(64'h100 + i));
      end
      check("t3_level_empty", level, 0);
      tick();
      check("t3_no_fifth", {take_action, take_no_action, cmd_valid}, 0);
      check("t3_jdo_hold", jdo, 38'h103);
      cmd_ready = 1'b0;

      // test 4: clear overflow, refill, then push coincident with pop while full
      overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
      check("t4_ovf_cleared", overflow, 0);
      for (int i = 0; i < 4; i++)
         pulse_udr(2'(i), 38'(64'h200 + i));
      check("t4_full", level, 4);
      d4 = 38'h20_0000_0BEE;
      ir_in = 2'd2; sr = d4; vs_udr = 1'b1;
      tick(); tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("t4_pushpop_level", level, 4);
      check("t4_pushpop_ovf", overflow, 0);
      check("t4_pushpop_pulse", take_no_action, 4'b0001);
      repeat (2) tick();
      vs_udr = 1'b0;
      repeat (4) tick();
      // drop with overflow_clr asserted on the same edge
      ir_in = 2'd3; sr = 38'h0; vs_udr = 1'b1;
      tick(); tick();
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      check("t4_set_beats_clr", overflow, 1);
      check("t4_drop_level", level, 4);
      repeat (2) tick();
      vs_udr = 1'b0;
      repeat (4) tick();
      cmd_ready = 1'b1;
      repeat (4) tick();
      cmd_ready = 1'b0;
      check("t4_last_jdo", jdo, d4);
      check("t4_last_act", take_action, 4'b0100);
      check("t4_drained", level, 0);
      overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;

      // test 5: short vs_uir pulse gives exactly one ir_update
      cnt = 0;
      vs_uir = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 4) vs_uir = 1'b0;
         tick();
         if (ir_update === 1'b1) cnt++;
      end
      check("t5_ir_update_count", cnt, 1);
      check("t5_no_push", {cmd_valid, level}, 0);

      // test 6: reset mid-drain
      for (int i = 0; i < 4; i++)
         pulse_udr(2'(i), 38'(64'h20_0000_0300 + i));
      cmd_ready = 1'b1;
      tick();
      check("t6_level3", level, 3);
      check("t6_pulse_before_rst", take_action, 4'b0001);
      reset = 1'b1;
      #1;
      check("t6_rst_outputs", {cmd_valid, cmd_ir, take_action, take_no_action, level, overflow, ir_update}, 0);
      check("t6_rst_jdo", jdo, 0);
      tick(); tick();
      reset = 1'b0;
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (take_action !== 4'b0 || take_no_action !== 4'b0 || cmd_valid !== 1'b0) bad = 1'b1;
      end
      check("t6_no_pulse_after", bad, 0);
      cmd_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
